// File: rtl/mixcol_seq_if.sv
// mixcol_seq_if: start/finish handshake and 128-bit data bus of the MixColumns engine (rev 1.0).
`default_nettype none

interface mixcol_seq_if;
  logic         mixcol_enable;
  logic         inv_mode;
  logic [127:0] olddata;
  logic [127:0] newdata;
  logic         mixcol_busy;
  logic         mixcol_finished;

  modport master (
    output mixcol_enable, inv_mode, olddata,
    input  newdata, mixcol_busy, mixcol_finished
  );

  modport slave (
    input  mixcol_enable, inv_mode, olddata,
    output newdata, mixcol_busy, mixcol_finished
  );
endinterface

`default_nettype wire

// File: rtl/mixcol_seq.sv
// mixcol_seq: iterative AES MixColumns, COLS_PER_CYCLE columns per clock (rev 1.0).
// Define MIXCOL_INV_EN to build the InvMixColumns datapath selected by inv_mode.
`default_nettype none

module mixcol_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  mixcol_seq_if.slave bus
);

  localparam int NCYC = 4 / COLS_PER_CYCLE;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_cpc_check
    $fatal(1, "mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [127:0]   data_q;
  logic [127:0]   newdata_q;
  logic           busy_q;
  logic           fin_q;
  logic [127:0]   newdata_d;
  logic [31:0]    col_in  [COLS_PER_CYCLE];
  logic [31:0]    col_out [COLS_PER_CYCLE];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Column word: row r lives in bits [8r+7:8r]; matrix rows are rotations of row 0.
  function automatic logic [31:0] mix_fwd(input logic [31:0] a);
    logic [31:0] y;
    logic [7:0]  b0, b1, b2, b3;
    y = '0;
    for (int r = 0; r < 4; r++) begin
      b0 = a[8*r +: 8];
      b1 = a[8*((r+1)%4) +: 8];
      b2 = a[8*((r+2)%4) +: 8];
      b3 = a[8*((r+3)%4) +: 8];
      y[8*r +: 8] = xt(b0) ^ (xt(b1) ^ b1) ^ b2 ^ b3;
    end
    return y;
  endfunction

`ifdef MIXCOL_INV_EN
  logic inv_q;

  function automatic logic [31:0] mix_inv(input logic [31:0] a);
    logic [31:0] y;
    logic [7:0]  b  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    y = '0;
    for (int r = 0; r < 4; r++) begin
      b[r]  = a[8*r +: 8];
      x2[r] = xt(b[r]);
      x4[r] = xt(x2[r]);
      x8[r] = xt(x4[r]);
    end
    // e at r, b at r+1, d at r+2, 9 at r+3
    for (int r = 0; r < 4; r++) begin
      y[8*r +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                  ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ b[(r+1)%4])
                  ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ b[(r+2)%4])
                  ^ (x8[(r+3)%4] ^ b[(r+3)%4]);
    end
    return y;
  endfunction
`else
  logic w_unused_inv;
  assign w_unused_inv = bus.inv_mode;
`endif

  always_comb begin
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_in[j] = '0;
      for (int n = 0; n < NCYC; n++) begin
        if (cnt_q == CW'(n)) begin
          for (int r = 0; r < 4; r++) begin
            col_in[j][8*r +: 8] = data_q[8*((n*COLS_PER_CYCLE + j) + 4*r) +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
`ifdef MIXCOL_INV_EN
      col_out[j] = inv_q ? mix_inv(col_in[j]) : mix_fwd(col_in[j]);
`else
      col_out[j] = mix_fwd(col_in[j]);
`endif
    end
  end

  always_comb begin
    newdata_d = newdata_q;
    for (int n = 0; n < NCYC; n++) begin
      if (cnt_q == CW'(n)) begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          for (int r = 0; r < 4; r++) begin
            newdata_d[8*((n*COLS_PER_CYCLE + j) + 4*r) +: 8] = col_out[j][8*r +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      newdata_q <= '0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
`ifdef MIXCOL_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.mixcol_enable) begin
            data_q  <= bus.olddata;
`ifdef MIXCOL_INV_EN
            inv_q   <= bus.inv_mode;
`endif
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          newdata_q <= newdata_d;
          if (cnt_q == CW'(NCYC - 1)) begin
            fin_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.newdata         = newdata_q;
  assign bus.mixcol_busy     = busy_q;
  assign bus.mixcol_finished = fin_q;

endmodule

`default_nettype wire

// File: doc/mixcol_seq.md
Name: mixcol_seq

Overview:
- Iterative, registered AES MixColumns engine: the parametrised successor of the combinational mixcol stage.
- Processes COLS_PER_CYCLE columns per clock with correct GF(2^8) arithmetic.
- Supports forward and, optionally, inverse MixColumns.
- Sits between the shift-rows and add-round-key stages; the round controller drives it with an enable/finished handshake.

Parameters:
- COLS_PER_CYCLE, 1: columns processed per compute cycle. Legal values are 1, 2 and 4; any other value is a fatal elaboration error.
- NCYC, 4/COLS_PER_CYCLE: derived, not overridable. Number of compute cycles.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous, active-low reset
- mixcol_enable  input  1  start request; sampled only in IDLE
- inv_mode  input  1  1 = InvMixColumns, 0 = MixColumns; latched at start
- olddata  input  128  state in; byte k = olddata[8k+7:8k]
- newdata  output  128  result register, same byte layout
- mixcol_busy  output  1  high in CALC and DONE
- mixcol_finished  output  1  one-cycle pulse, result valid

Behaviour:
- Byte layout:
  - Column c (0..3) = bytes k = c, c+4, c+8, c+12, which are rows 0..3.
  - Output bytes use the same positions.
- Forward matrix: rows [2 3 1 1], [1 2 3 1], [1 1 2 3], [3 1 1 2].
- Inverse matrix: rows [e b d 9], [9 e b d], [d 9 e b], [b d 9 e].
- GF arithmetic:
  - Multiplication is GF(2^8) modulo 0x11B.
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 0).
  - 3a = xtime(a)^a. 9, b, d and e are built from chained xtime plus XOR.
  - No integer multiply anywhere. Every product is exactly 8 bits.
- Reset (n_rst low, asynchronous):
  - State = IDLE; newdata = 0; mixcol_finished = 0; mixcol_busy = 0.
  - Column counter = 0; internal data register = 0; latched mode = 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: if mixcol_enable = 1, latch olddata into the working register, latch inv_mode, clear the counter, go to CALC. Otherwise stay.
  - CALC: each cycle, transform columns cnt*COLS_PER_CYCLE .. cnt*COLS_PER_CYCLE+COLS_PER_CYCLE-1 from the working register. Write the result columns into the newdata register. Increment cnt. When cnt = NCYC-1, go to DONE.
  - DONE: mixcol_finished = 1 for exactly this cycle; next state is IDLE.
- Latency:
  - Enable is sampled at edge 0.
  - Compute occupies edges 1..NCYC.
  - mixcol_finished is high in the cycle after edge NCYC.
  - Start to finished = NCYC+1 cycles: 5 / 3 / 2 for COLS_PER_CYCLE = 1 / 2 / 4.
- newdata update and hold:
  - Columns update as they are computed.
  - The value is guaranteed complete only when mixcol_finished = 1.
  - newdata holds its value until the next start's first CALC write.
- mixcol_enable while busy (CALC or DONE) is ignored; no queuing.
- Enable held high continuously: a new operation starts on the IDLE cycle after each DONE. Throughput is one block per NCYC+2 cycles.
- olddata and inv_mode may change after the start cycle without affecting the operation in flight.
- Reset mid-operation:
  - Immediate abort; all outputs go to reset values.
  - mixcol_finished is not pulsed for the aborted block.
- Counter width = max(1, clog2(NCYC)). It does not wrap within an operation.

Optional Feature:
- Macro: MIXCOL_INV_EN.
- Defined: inv_mode selects the inverse matrix per operation, as above.
- Undefined:
  - Inverse multipliers are not synthesised.
  - inv_mode is ignored; the engine always performs forward MixColumns.
  - The port remains present for interface stability.

Test Plan:
- Forward, COLS_PER_CYCLE=1:
  - Stimulus: column 0 bytes {db,13,53,45} at k=0,4,8,12; columns 1..3 {f2,0a,22,5c}, {01,01,01,01}, {c6,c6,c6,c6}.
  - Required: column 0 -> {8e,4d,a1,bc}, column 1 -> {9f,dc,58,9d}, columns 2 and 3 unchanged.
  - mixcol_finished is high exactly 5 cycles after the enable edge, for 1 cycle.
- Inverse (MIXCOL_INV_EN defined), COLS_PER_CYCLE=4:
  - Stimulus: columns {8e,4d,a1,bc} and {9f,dc,58,9d}.
  - Required: {db,13,53,45} and {f2,0a,22,5c}; finished 2 cycles after start.
- Parameter sweep: random 128-bit inputs at COLS_PER_CYCLE = 1, 2 and 4 each produce results bit-identical to the golden model. Inverse(forward(x)) = x when MIXCOL_INV_EN is defined.
- Busy handling:
  - Pulse mixcol_enable in CALC with different olddata: result is unchanged and there is no extra finished pulse.
  - Hold enable high: finished pulses every NCYC+2 cycles.
- Reset: drop n_rst in the 2nd CALC cycle. Required: newdata = 0, busy = 0 and finished = 0 immediately, and no finished pulse after release.
- Build without MIXCOL_INV_EN: inv_mode = 1 with {db,13,53,45} still yields {8e,4d,a1,bc}.
